alu_operand_loader: RTL and testbench

- Board-facing sequencer directly upstream of the 32-bit multifunction ALU.
- Assembles operands AA and BB from an 8-bit switch bank, one byte per debounced Load pulse, MSB byte first, and latches the 3-bit ALU_OP.
- Holds the operands stable for one evaluation cycle, then captures the ALU's F/ZF/OF into result registers for the display stage.

---
 rtl/alu_operand_loader_pkg.sv | 16 +
 rtl/alu_operand_loader_operand_shreg.sv | 25 ++
 rtl/alu_operand_loader.sv | 143 ++++++++++++++
 tb/tb_alu_operand_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_loader_pkg.sv
// Shared constants and state encoding for the ALU operand loader.
// The display stage decodes State for LEDs using the same enum.
package alu_operand_loader_pkg;

  localparam int DATA_W = 32;
  localparam int SW_W   = 8;
  localparam int BYTES  = DATA_W / SW_W;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    SHOW   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_operand_loader_operand_shreg.sv
// Operand shift register: shifts one switch byte in at the LSB end.
// Synchronous clear has priority over the load enable.
module operand_shreg
  import alu_operand_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [SW_W-1:0]   din_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= {q_q[DATA_W-SW_W-1:0], din_i};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Byte-wise operand sequencer in front of the 32-bit ALU.
// Loads A then B MSB first, evaluates for one cycle, captures result.
module alu_operand_loader
  import alu_operand_loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [SW_W-1:0]   SW,
  input  logic              Load,
  input  logic              Clear,
  input  logic [2:0]        OpSel,
  output logic [DATA_W-1:0] AA,
  output logic [DATA_W-1:0] BB,
  output logic [2:0]        ALU_OP,
  input  logic [DATA_W-1:0] F,
  input  logic              ZF,
  input  logic              OF,
  output logic [DATA_W-1:0] Result,
  output logic              ResZF,
  output logic              ResOF,
  output logic              Valid,
  output logic [1:0]        State,
  output logic [1:0]        ByteIdx
);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zf_q, zf_d;
  logic              of_q, of_d;
  logic              valid_q, valid_d;
  logic              ld_a, ld_b, clr_ops;
  logic              last_byte;

  assign last_byte = (idx_q == 2'(BYTES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    res_d   = res_q;
    zf_d    = zf_q;
    of_d    = of_q;
    valid_d = valid_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    clr_ops = 1'b0;
    unique case (state_q)
      LOAD_A: if (Load) begin
        ld_a = 1'b1;
        if (last_byte) begin
          idx_d   = '0;
          state_d = LOAD_B;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      LOAD_B: if (Load) begin
        ld_b = 1'b1;
        if (last_byte) begin
          idx_d   = '0;
          op_d    = OpSel;
          state_d = EXEC;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      EXEC: begin
        res_d   = F;
        zf_d    = ZF;
        of_d    = OF;
        valid_d = 1'b1;
        state_d = SHOW;
      end
      SHOW: if (Load) begin
        // Restart pulse only; no byte is taken from SW.
        clr_ops = 1'b1;
        idx_d   = '0;
        valid_d = 1'b0;
        state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
    if (Clear) begin
      ld_a    = 1'b0;
      ld_b    = 1'b0;
      clr_ops = 1'b1;
      idx_d   = '0;
      op_d    = '0;
      res_d   = '0;
      zf_d    = 1'b0;
      of_d    = 1'b0;
      valid_d = 1'b0;
      state_d = LOAD_A;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zf_q    <= zf_d;
      of_q    <= of_d;
      valid_q <= valid_d;
    end
  end

  operand_shreg u_shreg_a (
    .clk_i (CLK),
    .clr_i (!RST_N || clr_ops),
    .en_i  (ld_a),
    .din_i (SW),
    .q_o   (AA)
  );

  operand_shreg u_shreg_b (
    .clk_i (CLK),
    .clr_i (!RST_N || clr_ops),
    .en_i  (ld_b),
    .din_i (SW),
    .q_o   (BB)
  );

  assign ALU_OP  = op_q;
  assign Result  = res_q;
  assign ResZF   = zf_q;
  assign ResOF   = of_q;
  assign Valid   = valid_q;
  assign State   = state_q;
  assign ByteIdx = idx_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: reference ALU, sequence-level model,
// directed scenarios followed by randomized pulses.
module tb_alu_operand_loader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  SW = '0;
  logic        Load = 1'b0;
  logic        Clear = 1'b0;
  logic [2:0]  OpSel = '0;
  logic [31:0] AA, BB, F, Result;
  logic [2:0]  ALU_OP;
  logic        ZF, OF, ResZF, ResOF, Valid;
  logic [1:0]  State, ByteIdx;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  alu_operand_loader dut (
    .CLK(CLK), .RST_N(RST_N), .SW(SW), .Load(Load), .Clear(Clear),
    .OpSel(OpSel), .AA(AA), .BB(BB), .ALU_OP(ALU_OP), .F(F), .ZF(ZF),
    .OF(OF), .Result(Result), .ResZF(ResZF), .ResOF(ResOF),
    .Valid(Valid), .State(State), .ByteIdx(ByteIdx)
  );

  // Reference ALU: returns {OF, ZF, F}
  function automatic logic [33:0] alu(input logic [31:0] a, b,
                                      input logic [2:0] op);
    logic [31:0] f;
    logic        o;
    o = 1'b0;
    case (op)
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: f = a ^ b;
      3'd3: f = ~(a | b);
      3'd4: begin
        f = a + b;
        o = (a[31] == b[31]) && (f[31] != a[31]);
      end
      3'd5: begin
        f = a - b;
        o = (a[31] != b[31]) && (f[31] != a[31]);
      end
      3'd6: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: f = a;
    endcase
    return {o, (f == 32'd0), f};
  endfunction

  always_comb {OF, ZF, F} = alu(AA, BB, ALU_OP);

  // Sequence-level model: phase 0/1 = collecting A/B bytes, 2 = eval, 3 = show
  int          m_phase, m_cnt;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0]  m_op;
  logic        m_zf, m_of, m_valid;

  task automatic model(input logic rn, ld, cl, input logic [7:0] sw,
                       input logic [2:0] op);
    logic [33:0] r;
    if (!rn || cl) begin
      m_phase = 0; m_cnt = 0; m_a = 0; m_b = 0; m_op = 0;
      m_res = 0; m_zf = 0; m_of = 0; m_valid = 0;
    end else begin
      case (m_phase)
        0, 1: if (ld) begin
          if (m_phase == 0) m_a = m_a * 256 + 32'(sw);
          else              m_b = m_b * 256 + 32'(sw);
          m_cnt++;
          if (m_cnt == 4) begin
            m_cnt = 0;
            if (m_phase == 1) m_op = op;
            m_phase++;
          end
        end
        2: begin
          r = alu(m_a, m_b, m_op);
          {m_of, m_zf, m_res} = r;
          m_valid = 1;
          m_phase = 3;
        end
        default: if (ld) begin
          m_a = 0; m_b = 0; m_cnt = 0; m_valid = 0; m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  name, act, exp, $time);
  endtask

  always @(negedge CLK) if (chk_en) begin
    cmp("AA", AA, m_a);
    cmp("BB", BB, m_b);
    cmp("ALU_OP", 32'(ALU_OP), 32'(m_op));
    cmp("Result", Result, m_res);
    cmp("ResZF", 32'(ResZF), 32'(m_zf));
    cmp("ResOF", 32'(ResOF), 32'(m_of));
    cmp("Valid", 32'(Valid), 32'(m_valid));
    cmp("State", 32'(State), 32'(m_phase));
    cmp("ByteIdx", 32'(ByteIdx), 32'(m_cnt));
  end

  task automatic step(input logic rn, ld, cl, input logic [7:0] sw,
                      input logic [2:0] op);
    RST_N = rn; Load = ld; Clear = cl; SW = sw; OpSel = op;
    @(posedge CLK);
    model(rn, ld, cl, sw, op);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
  endtask

  task automatic load_word(input logic [31:0] w, input logic [2:0] op);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, w[31-8*i -: 8], op);
  endtask

  task automatic run_op(input logic [31:0] a, b, input logic [2:0] op);
    load_word(a, op);
    load_word(b, op);
    idle();
  endtask

  task automatic restart();
    step(1'b1, 1'b1, 1'b0, 8'hA5, 3'd0);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    chk_en = 1'b1;
    cmp("rst_state", 32'(State), 32'd0);
    cmp("rst_valid", 32'(Valid), 32'd0);
    cmp("rst_result", Result, 32'd0);

    load_word(32'h12345678, 3'b100);
    load_word(32'h00000001, 3'b100);
    cmp("t1_AA", AA, 32'h12345678);
    cmp("t1_BB", BB, 32'h00000001);
    cmp("t1_exec_valid", 32'(Valid), 32'd0);
    idle();
    cmp("t1_valid", 32'(Valid), 32'd1);
    cmp("t1_result", Result, 32'h12345679);
    cmp("t1_zf", 32'(ResZF), 32'd0);
    restart();

    run_op(32'hDEADBEEF, 32'hDEADBEEF, 3'b101);
    cmp("t2_result", Result, 32'h0);
    cmp("t2_zf", 32'(ResZF), 32'd1);
    restart();

    run_op(32'h7FFFFFFF, 32'h1, 3'b100);
    cmp("t3_result", Result, 32'h80000000);
    cmp("t3_of", 32'(ResOF), 32'd1);
    restart();

    load_word(32'hCAFEF00D, 3'd0);
    step(1'b1, 1'b1, 1'b0, 8'h11, 3'd0);
    step(1'b1, 1'b1, 1'b0, 8'h22, 3'd0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 3'd0);
    cmp("t4_state", 32'(State), 32'd0);
    cmp("t4_AA", AA, 32'h0);
    cmp("t4_BB", BB, 32'h0);
    cmp("t4_idx", 32'(ByteIdx), 32'd0);
    cmp("t4_valid", 32'(Valid), 32'd0);
    run_op(32'd3, 32'd5, 3'b000);
    cmp("t4_result", Result, 32'd1);
    restart();

    load_word(32'h11, 3'd0);
    load_word(32'h22, 3'b100);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 3'd0);
    cmp("t5_BB", BB, 32'h22);
    cmp("t5_state", 32'(State), 32'd3);
    cmp("t5_result", Result, 32'h33);
    restart();
    cmp("t5_show_state", 32'(State), 32'd0);
    cmp("t5_show_AA", AA, 32'h0);
    cmp("t5_show_idx", 32'(ByteIdx), 32'd0);
    cmp("t5_old_result", Result, 32'h33);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h9C, 3'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    cmp("t6_AA", AA, 32'h0);
    cmp("t6_idx", 32'(ByteIdx), 32'd0);
    cmp("t6_result", Result, 32'h0);
    step(1'b1, 1'b1, 1'b0, 8'h44, 3'd0);
    step(1'b1, 1'b1, 1'b1, 8'hAB, 3'd0);
    cmp("t6_clr_AA", AA, 32'h0);
    cmp("t6_clr_idx", 32'(ByteIdx), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      step((r != 0), 1'($urandom_range(0, 1)), (r < 4 && r != 0),
           8'($urandom), 3'($urandom));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
